// File: rtl/bcd_pkg.sv
// Shared constants, action encoding and a BCD legality helper for the BCD counter core.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  localparam int BTN_INC    = 0;
  localparam int BTN_DEC    = 1;
  localparam int BTN_PRESET = 2;
  localparam int BTN_CLEAR  = 3;

  typedef enum logic [2:0] {
    NONE,
    INC,
    DEC,
    PRESET,
    CLEAR
  } action_e;

  // True when every one of the low 'digits' nibbles holds a decimal digit.
  function automatic logic bcd_is_valid(input logic [63:0] value, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < digits; i++) begin
      if (value[DIGIT_W*i +: DIGIT_W] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit stage; the carry/borrow input enables the step.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               up,
  input  logic               down,
  input  logic               cin,
  output logic [DIGIT_W-1:0] next,
  output logic               cout
);

  always_comb begin
    next = digit;
    cout = 1'b0;
    if (cin && up) begin
      if (digit == BCD_MAX) begin
        next = '0;
        cout = 1'b1;
      end else begin
        next = digit + 4'd1;
      end
    end else if (cin && down) begin
      if (digit == '0) begin
        next = BCD_MAX;
        cout = 1'b1;
      end else begin
        next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_core.sv
// Multi-digit BCD up/down counter driven by rising edges of sanitized buttons.
// Define BCD_SATURATE_EN to hold at the limits instead of wrapping.
module bcd_counter_core
  import bcd_pkg::*;
#(
  parameter int                            NumDigits   = 4,
  parameter logic [DIGIT_W*NumDigits-1:0] PresetValue = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     btn_in,
  output logic [DIGIT_W*NumDigits-1:0]   count,
  output logic                           carry_out,
  output logic                           borrow_out
);

  logic [3:0]                   prev_btn;
  logic [3:0]                   evt;
  action_e                      action;
  logic [NumDigits:0]           chain;
  logic [DIGIT_W*NumDigits-1:0] stepped;
  logic                         wrap;
  logic [DIGIT_W*NumDigits-1:0] count_d;
  logic                         carry_d;
  logic                         borrow_d;

  assign evt = btn_in & ~prev_btn;

  // One action per cycle; simultaneous Inc and Dec cancel each other.
  always_comb begin
    action = NONE;
    if (evt[BTN_CLEAR])                      action = CLEAR;
    else if (evt[BTN_PRESET])                action = PRESET;
    else if (evt[BTN_INC] && !evt[BTN_DEC])  action = INC;
    else if (evt[BTN_DEC] && !evt[BTN_INC])  action = DEC;
  end

  assign chain[0] = 1'b1;

  for (genvar i = 0; i < NumDigits; i++) begin : g_digit
    bcd_digit u_digit (
      .digit (count[DIGIT_W*i +: DIGIT_W]),
      .up    (action == INC),
      .down  (action == DEC),
      .cin   (chain[i]),
      .next  (stepped[DIGIT_W*i +: DIGIT_W]),
      .cout  (chain[i+1])
    );
  end

  // A carry/borrow out of the top digit means the count hit a limit.
  assign wrap = chain[NumDigits];

  always_comb begin
    count_d  = count;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    case (action)
      CLEAR:  count_d = '0;
      PRESET: count_d = PresetValue;
      INC: begin
        carry_d = wrap;
`ifdef BCD_SATURATE_EN
        if (!wrap) count_d = stepped;
`else
        count_d = stepped;
`endif
      end
      DEC: begin
        borrow_d = wrap;
`ifdef BCD_SATURATE_EN
        if (!wrap) count_d = stepped;
`else
        count_d = stepped;
`endif
      end
      default: ;
    endcase
  end

  // Capturing the buttons during reset swallows a press held through it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      prev_btn   <= btn_in;
    end else begin
      count      <= count_d;
      carry_out  <= carry_d;
      borrow_out <= borrow_d;
      prev_btn   <= btn_in;
    end
  end

  preset_is_bcd: assert property (@(posedge clk) bcd_is_valid(64'(PresetValue), NumDigits));

endmodule
